// File: rtl/aer_spike_serializer.sv
// aer_spike_serializer: captures parallel spike pulses, arbitrates them round-robin
// and queues them as timestamped address-events behind a valid/ready handshake.
module aer_spike_serializer #(
  parameter int N_NEURONS  = 4,
  parameter int ADDR_W     = 2,
  parameter int TS_W       = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [N_NEURONS-1:0]          spike_in,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [ADDR_W-1:0]             ev_addr,
  output logic [TS_W-1:0]               ev_time,
  output logic [N_NEURONS-1:0]          pending,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    drop_cnt
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = ADDR_W + TS_W;
  localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);
  logic [TS_W-1:0] ts_q, ts_d;
  logic [N_NEURONS-1:0] pending_q, pending_d, gnt;
  logic [ADDR_W-1:0] ptr_q, ptr_d, gnt_idx;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0] level_q, level_d;
  logic [EW-1:0] head_q, head_d, push_data;
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [7:0] drop_q, drop_d;
  logic pop, push;
  int idx, ndrop;

  assign pop = (level_q != '0) && ev_ready;
  assign push_data = {gnt_idx, ts_q};
  assign gnt = push ? (N_NEURONS'(1) << gnt_idx) : '0;

  // Search starts at ptr_q, which always holds last_grant+1 (mod N)
  always_comb begin
    push = 1'b0;
    gnt_idx = '0;
    idx = 0;
    for (int k = 0; k < N_NEURONS; k++) begin
      idx = (int'(ptr_q) + k) % N_NEURONS;
      if (!push && pending_q[idx] && (level_q != FULL || pop)) begin
        push = 1'b1;
        gnt_idx = ADDR_W'(idx);
      end
    end
  end

  always_comb begin
    ndrop = 0;
    for (int i = 0; i < N_NEURONS; i++)
      ndrop = ndrop + int'(enable & spike_in[i] & pending_q[i] & ~gnt[i]);
    drop_d = (int'(drop_q) + ndrop > 255) ? 8'hFF : drop_q + 8'(ndrop);
    pending_d = (pending_q & ~gnt) | (enable ? spike_in : '0);
    ts_d = enable ? ts_q + TS_W'(1) : ts_q;
    ptr_d = !push ? ptr_q : (int'(gnt_idx) == N_NEURONS-1) ? '0 : gnt_idx + ADDR_W'(1);
    wr_d = wr_q + PW'(push);
    rd_d = rd_q + PW'(pop);
    level_d = level_q + (PW+1)'(push) - (PW+1)'(pop);
    // When the only surviving entry is this cycle's push, it bypasses the memory read
    head_d = (level_d == '0) ? head_q : (level_q == (PW+1)'(pop)) ? push_data : mem_q[rd_d];
  end

  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= push_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q      <= '0;
      pending_q <= '0;
      ptr_q     <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      level_q   <= '0;
      head_q    <= '0;
      drop_q    <= '0;
    end else begin
      ts_q      <= ts_d;
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      level_q   <= level_d;
      head_q    <= head_d;
      drop_q    <= drop_d;
    end
  end

  assign ev_valid = level_q != '0;
  assign {ev_addr, ev_time} = head_q;
  assign pending = pending_q;
  assign fifo_level = level_q;
  assign drop_cnt = drop_q;
endmodule

// File: tb/tb_aer_spike_serializer.sv
// tb_aer_spike_serializer: directed vectors, corner sequences and random traffic
// checked every cycle against a queue-based event model.
module tb_aer_spike_serializer;
  localparam int N = 4, D = 8;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, ev_ready = 1'b0;
  logic [3:0] spike_in = '0;
  logic ev_valid;
  logic [1:0] ev_addr;
  logic [7:0] ev_time, drop_cnt;
  logic [3:0] pending, fifo_level;
  int checks = 0, errors = 0;
  int q[$];
  int m_pend[N];
  int m_ts, m_ptr, m_drop, m_head;

  typedef struct {
    bit rst; bit en; bit [3:0] spk; bit rdy;
    bit v; int addr; int tm; int lvl;
  } vec_t;
  vec_t tbl[13];

  always #5 clk = ~clk;

  aer_spike_serializer #(.N_NEURONS(N), .ADDR_W(2), .TS_W(8), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .spike_in(spike_in),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_addr(ev_addr), .ev_time(ev_time),
    .pending(pending), .fifo_level(fifo_level), .drop_cnt(drop_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < N; i++) m_pend[i] = 0;
    m_ts = 0; m_ptr = 0; m_drop = 0; m_head = 0;
  endtask

  // Event-level model: queue of {addr,ts}, round-robin scan, per-bit drop rule
  task automatic model_edge(input bit en, input logic [3:0] spk, input bit rdy);
    int g;
    if (q.size() > 0 && rdy) void'(q.pop_front());
    g = -1;
    for (int k = 0; k < N; k++)
      if (g < 0 && m_pend[(m_ptr + k) % N] != 0 && q.size() < D) g = (m_ptr + k) % N;
    if (g >= 0) begin
      q.push_back(g * 256 + m_ts);
      m_pend[g] = 0;
      m_ptr = (g + 1) % N;
    end
    if (en) begin
      for (int i = 0; i < N; i++)
        if (spk[i]) begin
          if (m_pend[i] != 0) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
          else m_pend[i] = 1;
        end
      m_ts = (m_ts + 1) % 256;
    end
    if (q.size() > 0) m_head = q[0];
  endtask

  task automatic compare_all();
    logic [3:0] p;
    for (int i = 0; i < N; i++) p[i] = (m_pend[i] != 0);
    chk("valid", ev_valid, q.size() > 0);
    chk("addr", ev_addr, m_head / 256);
    chk("time", ev_time, m_head % 256);
    chk("level", fifo_level, q.size());
    chk("pending", pending, p);
    chk("drop", drop_cnt, m_drop);
  endtask

  task automatic step(input bit en, input logic [3:0] spk, input bit rdy);
    enable = en; spike_in = spk; ev_ready = rdy;
    @(posedge clk);
    model_edge(en, spk, rdy);
    #1 compare_all();
  endtask

  task automatic async_reset();
    #3 rst_n = 1'b0;
    #1;
    chk("rst_valid", ev_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_pending", pending, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_addr", ev_addr, 0);
    chk("rst_time", ev_time, 0);
    model_reset();
    #2 rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 5; i++) tbl[i] = '{0, 1, 4'h0, 1, 0, 0, 0, 0};
    tbl[5]  = '{0, 1, 4'h4, 1, 0, 0, 0, 0};
    tbl[6]  = '{0, 1, 4'h0, 1, 1, 2, 6, 1};
    tbl[7]  = '{0, 1, 4'h0, 1, 0, 2, 6, 0};
    tbl[8]  = '{1, 1, 4'hB, 1, 0, 0, 0, 0};
    tbl[9]  = '{0, 1, 4'h0, 1, 1, 0, 1, 1};
    tbl[10] = '{0, 1, 4'h0, 1, 1, 1, 2, 1};
    tbl[11] = '{0, 1, 4'h0, 1, 1, 3, 3, 1};
    tbl[12] = '{0, 1, 4'h0, 1, 0, 3, 3, 0};
    model_reset();
    #3 compare_all();
    #9 rst_n = 1'b1;

    // Single spike at ts=5, then three simultaneous spikes after a fresh reset
    for (int i = 0; i < 13; i++) begin
      if (tbl[i].rst) async_reset();
      step(tbl[i].en, tbl[i].spk, tbl[i].rdy);
      chk("tbl_valid", ev_valid, tbl[i].v);
      chk("tbl_addr", ev_addr, tbl[i].addr);
      chk("tbl_time", ev_time, tbl[i].tm);
      chk("tbl_level", fifo_level, tbl[i].lvl);
    end
    chk("tbl_drop", drop_cnt, 0);

    // Back-pressure until full, hold stable, then drain
    async_reset();
    repeat (10) step(1, 4'hF, 0);
    chk("full_level", fifo_level, 8);
    chk("full_pending", pending, 4'hF);
    chk("full_drop", drop_cnt, 28);
    repeat (3) step(1, 4'h0, 0);
    chk("hold_addr", ev_addr, 0);
    chk("hold_time", ev_time, 1);
    repeat (14) step(1, 4'h0, 1);
    chk("drained", fifo_level, 0);

    // Continuous spike on bit 1 collides with its own grant every cycle
    async_reset();
    repeat (8) step(1, 4'h2, 1);
    chk("coll_pending", pending, 4'h2);
    chk("coll_drop", drop_cnt, 0);
    chk("coll_addr", ev_addr, 1);
    chk("coll_valid", ev_valid, 1);

    // Disabled capture: pending still drains with a frozen timestamp
    async_reset();
    step(1, 4'h5, 0);
    repeat (3) step(0, 4'hF, 0);
    chk("gate_level", fifo_level, 2);
    chk("gate_pending", pending, 0);
    chk("gate_drop", drop_cnt, 0);
    step(0, 4'hF, 1);
    chk("gate_addr", ev_addr, 2);
    chk("gate_time", ev_time, 1);

    // Async reset with three queued events
    async_reset();
    step(1, 4'h7, 0);
    repeat (3) step(1, 4'h0, 0);
    chk("pre_rst_level", fifo_level, 3);
    async_reset();

    // Random traffic against the model
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 9) != 0, 4'($urandom & $urandom), $urandom_range(0, 2) != 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
